// File: rtl/instruction_memory_loadable_if.sv
// Load and fetch bus of the loadable instruction memory.
// The master side is the boot loader / fetch stage; the slave side is the memory.
interface instruction_memory_loadable_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  load_start;
    logic                  load_valid;
    logic [7:0]            load_byte;
    logic                  load_last;
    logic                  load_ready;
    logic                  load_done;
    logic                  load_overflow;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  fetch_en;
    logic [31:0]           instr;
    logic                  instr_valid;
    logic                  fetch_fault;

    modport master (
        output load_start, load_valid, load_byte, load_last, pc, fetch_en,
        input  load_ready, load_done, load_overflow, instr, instr_valid, fetch_fault
    );

    modport slave (
        input  load_start, load_valid, load_byte, load_last, pc, fetch_en,
        output load_ready, load_done, load_overflow, instr, instr_valid, fetch_fault
    );
endinterface

// File: rtl/instruction_memory_loadable.sv
// Run-time loadable instruction RAM for the Fetch stage.
// A byte stream is packed little-endian into 32-bit words during LOAD;
// in RUN the fetch port returns one registered word per enabled cycle,
// holding on stall and flagging misaligned or out-of-range PCs.
module instruction_memory_loadable #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DEPTH_WORDS = 64,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter logic [31:0]           FILL_INSTR  = 32'h0000_0013
) (
    input logic                           clk,
    input logic                           reset,
    instruction_memory_loadable_if.slave  bus
);
    localparam int                    AW      = $clog2(DEPTH_WORDS);
    localparam int                    PW      = AW + 1;
    localparam logic [PW-1:0]         DEPTH_P = PW'(DEPTH_WORDS);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t                state;
    logic [31:0]           mem [DEPTH_WORDS];

    // Write pointer is one bit wider than the index so "full" is representable.
    logic [PW-1:0]         wr_ptr;
    logic [1:0]            byte_cnt;
    logic [31:0]           asm_word;
    logic [31:0]           asm_next;
    logic                  ptr_full;
    logic                  accept;
    logic                  word_done;
    logic                  wr_en;

    logic                  load_ready_q;
    logic                  load_done_q;
    logic                  load_overflow_q;

    logic                  under_p0;
    logic [ADDR_WIDTH-1:0] off_p0;
    logic [ADDR_WIDTH-1:0] idx_p0;
    logic                  fault_p0;

    logic [31:0]           instr_p1;
    logic                  vld_p1;
    logic                  fault_p1;

    // Merge the incoming byte into its lane; upper lanes stay zero from the clear.
    always_comb begin
        asm_next = asm_word;
        asm_next[{byte_cnt, 3'b000} +: 8] = bus.load_byte;
    end

    assign ptr_full  = (wr_ptr >= DEPTH_P);
    assign accept    = load_ready_q && bus.load_valid && !bus.load_start;
    assign word_done = (byte_cnt == 2'd3) || bus.load_last;
    assign wr_en     = accept && !ptr_full && word_done;

    // Fetch address decode: borrow out of the subtraction means pc < BASE_ADDR.
    always_comb begin
        {under_p0, off_p0} = {1'b0, bus.pc} - {1'b0, BASE_ADDR};
        idx_p0   = off_p0 >> 2;
        fault_p0 = (bus.pc[1:0] != 2'b00) || under_p0 || (idx_p0 >= DEPTH_A);
    end

    // Word write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= asm_next;
        end
    end

    // Load/run controller together with the registered fetch outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            load_ready_q    <= 1'b0;
            load_done_q     <= 1'b0;
            load_overflow_q <= 1'b0;
            wr_ptr          <= '0;
            byte_cnt        <= '0;
            asm_word        <= '0;
            instr_p1        <= FILL_INSTR;
            vld_p1          <= 1'b0;
            fault_p1        <= 1'b0;
        end else begin
            load_done_q <= 1'b0;
            if (bus.load_start) begin
                // A new load always wins, including over a byte offered this cycle.
                state           <= LOAD;
                load_ready_q    <= 1'b1;
                load_overflow_q <= 1'b0;
                wr_ptr          <= '0;
                byte_cnt        <= '0;
                asm_word        <= '0;
                instr_p1        <= FILL_INSTR;
                vld_p1          <= 1'b0;
                fault_p1        <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        instr_p1 <= FILL_INSTR;
                        vld_p1   <= 1'b0;
                        fault_p1 <= 1'b0;
                    end
                    LOAD: begin
                        instr_p1 <= FILL_INSTR;
                        vld_p1   <= 1'b0;
                        fault_p1 <= 1'b0;
                        if (accept) begin
                            if (ptr_full) begin
                                // Image larger than the RAM: drop the byte, never wrap.
                                load_overflow_q <= 1'b1;
                            end else if (word_done) begin
                                wr_ptr   <= wr_ptr + PW'(1);
                                byte_cnt <= '0;
                                asm_word <= '0;
                            end else begin
                                asm_word <= asm_next;
                                byte_cnt <= byte_cnt + 2'd1;
                            end
                            if (bus.load_last) begin
                                state        <= RUN;
                                load_ready_q <= 1'b0;
                                load_done_q  <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        // fetch_en low is a stall: outputs simply keep their value.
                        if (bus.fetch_en) begin
                            instr_p1 <= fault_p0 ? FILL_INSTR : mem[idx_p0[AW-1:0]];
                            vld_p1   <= 1'b1;
                            fault_p1 <= fault_p0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.load_ready    = load_ready_q;
    assign bus.load_done     = load_done_q;
    assign bus.load_overflow = load_overflow_q;
    assign bus.instr         = instr_p1;
    assign bus.instr_valid   = vld_p1;
    assign bus.fetch_fault   = fault_p1;
endmodule
